// File: rtl/foc_seq_pkg.sv
// rtl/foc_seq_pkg.sv - shared state encodings, mode constants and helpers for the FOC run sequencer
package foc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_ALIGN_UP   = 3'd2,
        ST_ALIGN_HOLD = 3'd3,
        ST_ALIGN_DN   = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAULT      = 3'd6
    } seq_state_t;

    localparam logic [1:0] MODE_CUR  = 2'd0;
    localparam logic [1:0] MODE_VEL  = 2'd1;
    localparam logic [1:0] MODE_POS  = 2'd2;
    localparam logic [1:0] MODE_OPEN = 2'd3;

    // 17-bit magnitude so that -32768 becomes +32768 instead of wrapping
    function automatic logic [16:0] abs17(input logic signed [15:0] x);
        logic signed [16:0] w_ext;
        w_ext = 17'(x);
        return w_ext[16] ? -w_ext : w_ext;
    endfunction

endpackage

// File: rtl/foc_oc_detect.sv
// rtl/foc_oc_detect.sv - three-phase over-current comparator with consecutive-sample trip counter
module foc_oc_detect
    import foc_seq_pkg::*;
#(
    parameter logic signed [15:0] OC_LIMIT = 16'sd3000,
    parameter logic        [3:0]  OC_COUNT = 4'd4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic signed [15:0] i_ia,
    input  logic signed [15:0] i_ib,
    input  logic signed [15:0] i_ic,
    output logic               o_trip,
    output logic [2:0]         o_phase
);

    localparam logic [16:0] L_LIMIT = 17'(OC_LIMIT);

    logic [2:0] w_over;
    logic       w_any;
    logic [3:0] r_cnt;

    assign w_over[0] = abs17(i_ia) > L_LIMIT;
    assign w_over[1] = abs17(i_ib) > L_LIMIT;
    assign w_over[2] = abs17(i_ic) > L_LIMIT;
    assign w_any     = |w_over;

    // The sample that completes the run trips immediately, so the FSM reacts on the same edge
    assign o_trip  = i_enable && i_valid && w_any && (r_cnt >= OC_COUNT - 4'd1);
    assign o_phase = w_over;

    // Count consecutive over-limit samples; any clean sample or leaving a monitored state restarts the run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_enable) begin
            r_cnt <= '0;
        end else if (i_valid) begin
            if (!w_any) begin
                r_cnt <= '0;
            end else if (r_cnt < OC_COUNT - 4'd1) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/foc_run_sequencer.sv
// rtl/foc_run_sequencer.sv - start-up/run/fault sequencer driving the FOC controller command inputs
module foc_run_sequencer
    import foc_seq_pkg::*;
#(
    parameter int                 TICK_DIV    = 40000,
    parameter logic signed [15:0] ALIGN_VD    = 16'sd2000,
    parameter logic signed [15:0] RAMP_STEP   = 16'sd100,
    parameter logic        [15:0] ALIGN_TICKS = 16'd500,
    parameter logic signed [15:0] OC_LIMIT    = 16'sd3000,
    parameter logic        [3:0]  OC_COUNT    = 4'd4
) (
    input  logic               I_clk_40m,
    input  logic               I_rst,
    input  logic               I_start,
    input  logic               I_fault_clr,
    input  logic [1:0]         I_host_mode,
    input  logic signed [15:0] I_host_id_aim,
    input  logic signed [15:0] I_host_iq_aim,
    input  logic signed [15:0] I_host_vel_aim,
    input  logic signed [15:0] I_host_pos_aim,
    input  logic signed [15:0] I_host_vd,
    input  logic signed [15:0] I_host_vq,
    input  logic               I_init_done,
    input  logic [11:0]        I_angle_mec,
    input  logic               I_cur_valid,
    input  logic signed [15:0] I_current_ia,
    input  logic signed [15:0] I_current_ib,
    input  logic signed [15:0] I_current_ic,
    output logic               O_en,
    output logic [1:0]         O_control_mode,
    output logic signed [15:0] O_id_aim,
    output logic signed [15:0] O_iq_aim,
    output logic signed [15:0] O_vel_aim,
    output logic signed [15:0] O_pos_aim,
    output logic signed [15:0] O_vd,
    output logic signed [15:0] O_vq,
    output logic [11:0]        O_angle_zero,
    output logic [2:0]         O_state,
    output logic               O_fault,
    output logic [2:0]         O_fault_phase
);

    localparam int                 TW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]      L_TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic signed [16:0] L_ALIGN_VD17 = 17'(ALIGN_VD);

    seq_state_t         r_state, w_next_state;
    logic [TW-1:0]      r_tick_cnt;
    logic               w_tick;
    logic [15:0]        r_hold_cnt, w_hold_next;
    logic               w_monitor, w_trip;
    logic [2:0]         w_trip_phase;
    logic signed [16:0] w_vd_up, w_vd_dn;
    logic signed [15:0] w_ramp;
    logic [11:0]        r_angle_zero, w_angle_next;
    logic [2:0]         r_fault_phase, w_phase_next;
    logic               r_en, w_en;
    logic [1:0]         r_mode, w_mode;
    logic signed [15:0] r_id, r_iq, r_vel, r_pos, r_vd, r_vq;
    logic signed [15:0] w_id, w_iq, w_vel, w_pos, w_vd, w_vq;

    assign w_tick    = (r_tick_cnt == L_TICK_LAST);
    assign w_monitor = (r_state == ST_ALIGN_UP) || (r_state == ST_ALIGN_HOLD) ||
                       (r_state == ST_ALIGN_DN) || (r_state == ST_RUN);
    // r_vd doubles as the ramp register while in the alignment states
    assign w_vd_up   = 17'(r_vd) + 17'(RAMP_STEP);
    assign w_vd_dn   = 17'(r_vd) - 17'(RAMP_STEP);

    foc_oc_detect #(
        .OC_LIMIT (OC_LIMIT),
        .OC_COUNT (OC_COUNT)
    ) u_oc_detect (
        .i_clk    (I_clk_40m),
        .i_rst    (I_rst),
        .i_enable (w_monitor),
        .i_valid  (I_cur_valid),
        .i_ia     (I_current_ia),
        .i_ib     (I_current_ib),
        .i_ic     (I_current_ic),
        .o_trip   (w_trip),
        .o_phase  (w_trip_phase)
    );

    // Free-running 1 kHz tick prescaler, independent of sequencer state
    always_ff @(posedge I_clk_40m or posedge I_rst) begin
        if (I_rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Next state, ramp value and registered output values; fault beats start drop beats init loss
    always_comb begin
        w_next_state = r_state;
        w_hold_next  = r_hold_cnt;
        w_ramp       = r_vd;
        w_angle_next = r_angle_zero;
        w_phase_next = r_fault_phase;
        if (w_trip) begin
            w_next_state = ST_FAULT;
            w_phase_next = w_trip_phase;
        end else if (r_state != ST_FAULT && !I_start) begin
            w_next_state = ST_IDLE;
        end else if (w_monitor && !I_init_done) begin
            w_next_state = ST_WAIT_INIT;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_WAIT_INIT;
                ST_WAIT_INIT: begin
                    if (I_init_done) begin
                        w_next_state = ST_ALIGN_UP;
                        w_ramp       = '0;
                    end
                end
                ST_ALIGN_UP: begin
                    if (w_tick) begin
                        if (w_vd_up >= L_ALIGN_VD17) begin
                            w_ramp       = ALIGN_VD;
                            w_next_state = ST_ALIGN_HOLD;
                            w_hold_next  = '0;
                        end else begin
                            w_ramp = w_vd_up[15:0];
                        end
                    end
                end
                ST_ALIGN_HOLD: begin
                    w_ramp = ALIGN_VD;
                    if (w_tick) begin
                        if (r_hold_cnt == ALIGN_TICKS - 16'd1) begin
                            w_angle_next = I_angle_mec;
                            w_next_state = ST_ALIGN_DN;
                        end else begin
                            w_hold_next = r_hold_cnt + 16'd1;
                        end
                    end
                end
                ST_ALIGN_DN: begin
                    if (r_vd == 16'sd0) begin
                        w_next_state = ST_RUN;
                    end else if (w_tick) begin
                        w_ramp = (w_vd_dn <= 17'sd0) ? 16'sd0 : w_vd_dn[15:0];
                    end
                end
                ST_RUN: ;
                ST_FAULT: begin
                    if (!I_start && I_fault_clr) begin
                        w_next_state = ST_IDLE;
                        w_phase_next = '0;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end

        w_en   = 1'b0;
        w_mode = MODE_OPEN;
        w_id   = '0;
        w_iq   = '0;
        w_vel  = '0;
        w_pos  = '0;
        w_vd   = '0;
        w_vq   = '0;
        case (w_next_state)
            ST_ALIGN_UP, ST_ALIGN_HOLD, ST_ALIGN_DN: begin
                w_en = 1'b1;
                w_vd = w_ramp;
            end
            ST_RUN: begin
                w_en   = 1'b1;
                w_mode = I_host_mode;
                w_id   = I_host_id_aim;
                w_iq   = I_host_iq_aim;
                w_vel  = I_host_vel_aim;
                w_pos  = I_host_pos_aim;
                w_vd   = I_host_vd;
                w_vq   = I_host_vq;
            end
            default: ;
        endcase
    end

    // State and output registers; reset clears everything including the captured zero angle
    always_ff @(posedge I_clk_40m or posedge I_rst) begin
        if (I_rst) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_angle_zero  <= '0;
            r_fault_phase <= '0;
            r_en          <= 1'b0;
            r_mode        <= MODE_OPEN;
            r_id          <= '0;
            r_iq          <= '0;
            r_vel         <= '0;
            r_pos         <= '0;
            r_vd          <= '0;
            r_vq          <= '0;
        end else begin
            r_state       <= w_next_state;
            r_hold_cnt    <= w_hold_next;
            r_angle_zero  <= w_angle_next;
            r_fault_phase <= w_phase_next;
            r_en          <= w_en;
            r_mode        <= w_mode;
            r_id          <= w_id;
            r_iq          <= w_iq;
            r_vel         <= w_vel;
            r_pos         <= w_pos;
            r_vd          <= w_vd;
            r_vq          <= w_vq;
        end
    end

    assign O_en           = r_en;
    assign O_control_mode = r_mode;
    assign O_id_aim       = r_id;
    assign O_iq_aim       = r_iq;
    assign O_vel_aim      = r_vel;
    assign O_pos_aim      = r_pos;
    assign O_vd           = r_vd;
    assign O_vq           = r_vq;
    assign O_angle_zero   = r_angle_zero;
    assign O_state        = r_state;
    assign O_fault        = (r_state == ST_FAULT);
    assign O_fault_phase  = r_fault_phase;

endmodule

// File: tb/tb_foc_run_sequencer.sv
// tb/tb_foc_run_sequencer.sv - scoreboard bench for foc_run_sequencer
module tb_foc_run_sequencer;

    localparam int AVD = 2000;
    localparam int RS  = 500;

    logic               I_clk_40m = 1'b0;
    logic               I_rst = 1'b1;
    logic               I_start = 1'b0;
    logic               I_fault_clr = 1'b0;
    logic [1:0]         I_host_mode = '0;
    logic signed [15:0] I_host_id_aim = '0, I_host_iq_aim = '0, I_host_vel_aim = '0;
    logic signed [15:0] I_host_pos_aim = '0, I_host_vd = '0, I_host_vq = '0;
    logic               I_init_done = 1'b0;
    logic [11:0]        I_angle_mec = '0;
    logic               I_cur_valid = 1'b0;
    logic signed [15:0] I_current_ia = '0, I_current_ib = '0, I_current_ic = '0;
    logic               O_en;
    logic [1:0]         O_control_mode;
    logic signed [15:0] O_id_aim, O_iq_aim, O_vel_aim, O_pos_aim, O_vd, O_vq;
    logic [11:0]        O_angle_zero;
    logic [2:0]         O_state;
    logic               O_fault;
    logic [2:0]         O_fault_phase;

    foc_run_sequencer #(
        .TICK_DIV    (40),
        .ALIGN_VD    (16'sd2000),
        .RAMP_STEP   (16'sd500),
        .ALIGN_TICKS (16'd5),
        .OC_LIMIT    (16'sd3000),
        .OC_COUNT    (4'd4)
    ) dut (
        .I_clk_40m(I_clk_40m), .I_rst(I_rst), .I_start(I_start), .I_fault_clr(I_fault_clr),
        .I_host_mode(I_host_mode), .I_host_id_aim(I_host_id_aim), .I_host_iq_aim(I_host_iq_aim),
        .I_host_vel_aim(I_host_vel_aim), .I_host_pos_aim(I_host_pos_aim), .I_host_vd(I_host_vd),
        .I_host_vq(I_host_vq), .I_init_done(I_init_done), .I_angle_mec(I_angle_mec),
        .I_cur_valid(I_cur_valid), .I_current_ia(I_current_ia), .I_current_ib(I_current_ib),
        .I_current_ic(I_current_ic), .O_en(O_en), .O_control_mode(O_control_mode),
        .O_id_aim(O_id_aim), .O_iq_aim(O_iq_aim), .O_vel_aim(O_vel_aim), .O_pos_aim(O_pos_aim),
        .O_vd(O_vd), .O_vq(O_vq), .O_angle_zero(O_angle_zero), .O_state(O_state),
        .O_fault(O_fault), .O_fault_phase(O_fault_phase)
    );

    always #5 I_clk_40m = ~I_clk_40m;

    typedef struct packed {
        logic [2:0]  st;
        logic        en;
        logic [1:0]  mode;
        logic [15:0] id, iq, vel, pos, vd, vq;
        logic        fault;
        logic [2:0]  ph;
        logic [11:0] az;
    } snap_t;

    snap_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_on = 1'b0;
    logic [11:0] m_az = '0;

    function automatic snap_t cur_snap();
        snap_t s;
        s.st = O_state; s.en = O_en; s.mode = O_control_mode;
        s.id = O_id_aim; s.iq = O_iq_aim; s.vel = O_vel_aim; s.pos = O_pos_aim;
        s.vd = O_vd; s.vq = O_vq; s.fault = O_fault; s.ph = O_fault_phase; s.az = O_angle_zero;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("st=%0d en=%0d mode=%0d id=%0d iq=%0d vel=%0d pos=%0d vd=%0d vq=%0d flt=%0d ph=%b az=%0d",
                         s.st, s.en, s.mode, $signed(s.id), $signed(s.iq), $signed(s.vel), $signed(s.pos),
                         $signed(s.vd), $signed(s.vq), s.fault, s.ph, s.az);
    endfunction

    // Quiet output set for a state: mode open-voltage, commands zero except the given vd
    function automatic snap_t base(input int st, input bit en, input int vd);
        snap_t s;
        s = '0;
        s.st = 3'(st); s.en = en; s.mode = 2'd3; s.vd = 16'(vd); s.az = m_az;
        return s;
    endfunction

    function automatic snap_t run_snap();
        snap_t s;
        s = base(5, 1'b1, 0);
        s.mode = I_host_mode; s.id = I_host_id_aim; s.iq = I_host_iq_aim; s.vel = I_host_vel_aim;
        s.pos = I_host_pos_aim; s.vd = I_host_vd; s.vq = I_host_vq;
        return s;
    endfunction

    // Monitor: every change of the observed outputs must be the next expected event
    initial begin
        snap_t prev, now, e;
        wait (mon_on);
        prev = cur_snap();
        forever begin
            @(negedge I_clk_40m);
            now = cur_snap();
            if (now !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got {%s} required unchanged {%s}", fmt(now), fmt(prev));
                end else begin
                    e = exp_q.pop_front();
                    if (now !== e) begin
                        n_fail++;
                        $display("FAIL output_event: got {%s} required {%s}", fmt(now), fmt(e));
                    end
                end
                prev = now;
            end
        end
    end

    task automatic drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge I_clk_40m);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending events, required 0 (next {%s})", exp_q.size(), fmt(exp_q[0]));
            exp_q.delete();
        end
        repeat (3) @(posedge I_clk_40m);
        #1;
    endtask

    // Reference start-up sequence: ramp up by RS to AVD, hold, capture, ramp down, enter RUN
    task automatic model_startup(input bit with_wait, input bit full, input logic [11:0] ang);
        int v = 0;
        if (with_wait) exp_q.push_back(base(1, 1'b0, 0));
        exp_q.push_back(base(2, 1'b1, 0));
        do begin
            v = (v + RS > AVD) ? AVD : v + RS;
            exp_q.push_back(base((v == AVD) ? 3 : 2, 1'b1, v));
        end while (v < AVD);
        if (!full) return;
        m_az = ang;
        exp_q.push_back(base(4, 1'b1, v));
        while (v > 0) begin
            v = (v - RS < 0) ? 0 : v - RS;
            exp_q.push_back(base(4, 1'b1, v));
        end
        exp_q.push_back(run_snap());
    endtask

    task automatic rand_host();
        I_host_mode    = 2'($urandom_range(0, 3));
        I_host_id_aim  = 16'($urandom);
        I_host_iq_aim  = 16'($urandom);
        I_host_vel_aim = 16'($urandom);
        I_host_pos_aim = 16'($urandom);
        I_host_vd      = 16'($urandom_range(1, 30000));
        I_host_vq      = 16'($urandom);
    endtask

    task automatic strobe(input logic signed [15:0] a, input logic signed [15:0] b, input logic signed [15:0] c);
        @(posedge I_clk_40m); #1;
        I_current_ia = a; I_current_ib = b; I_current_ic = c; I_cur_valid = 1'b1;
        @(posedge I_clk_40m); #1;
        I_cur_valid = 1'b0;
        @(posedge I_clk_40m); #1;
    endtask

    function automatic logic signed [15:0] rand_over();
        int mag;
        if ($urandom_range(0, 5) == 0) return -16'sd32768;
        mag = $urandom_range(3001, 32767);
        return ($urandom_range(0, 1) == 1) ? 16'(mag) : 16'(-mag);
    endfunction

    function automatic logic signed [15:0] rand_under();
        return 16'(int'($urandom_range(0, 6000)) - 3000);
    endfunction

    task automatic fault_and_clear(input logic [2:0] mask, input logic signed [15:0] a,
                                   input logic signed [15:0] b, input logic signed [15:0] c);
        snap_t f;
        f = base(6, 1'b0, 0);
        f.fault = 1'b1; f.ph = mask;
        exp_q.push_back(f);
        repeat (4) strobe(a, b, c);
        drain(50);
        I_fault_clr = 1'b1;
        repeat (30) @(posedge I_clk_40m);
        #1;
        exp_q.push_back(base(0, 1'b0, 0));
        I_start = 1'b0;
        drain(50);
        I_fault_clr = 1'b0;
    endtask

    task automatic full_run(input logic [11:0] ang);
        I_angle_mec = ang;
        rand_host();
        model_startup(1'b1, 1'b1, ang);
        I_start = 1'b1;
        I_init_done = 1'b1;
        drain(3000);
    endtask

    initial begin
        snap_t s;
        logic [2:0] mask;
        logic signed [15:0] ph [3];

        repeat (3) @(posedge I_clk_40m);
        #1;
        n_checks++;
        if (cur_snap() !== base(0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL reset_state: got {%s} required {%s}", fmt(cur_snap()), fmt(base(0, 1'b0, 0)));
        end
        I_rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(posedge I_clk_40m);
        #1;

        // Full start-up with a fixed angle and velocity command
        I_angle_mec = 12'd1234;
        rand_host();
        I_host_mode = 2'd1;
        I_host_vel_aim = 16'sd300;
        model_startup(1'b1, 1'b1, 12'd1234);
        I_start = 1'b1;
        I_init_done = 1'b1;
        drain(3000);

        // Host command changes in RUN pass through one cycle later
        for (int i = 0; i < 4; i++) begin
            I_host_mode = 2'($urandom_range(0, 3));
            I_host_vel_aim = I_host_vel_aim ^ 16'($urandom_range(1, 65535));
            I_host_iq_aim = 16'($urandom);
            exp_q.push_back(run_snap());
            drain(20);
        end

        // Near-misses: broken run of over-limit samples and samples exactly at the limit
        repeat (3) strobe(16'sd3001, 16'sd0, 16'sd0);
        strobe(16'sd0, 16'sd0, 16'sd0);
        repeat (3) strobe(16'sd3001, 16'sd0, 16'sd0);
        strobe(16'sd0, 16'sd0, 16'sd0);
        repeat (6) strobe(16'sd3000, -16'sd3000, 16'sd3000);
        drain(10);

        // Trip on phase a, fault clear ignored while start is high
        fault_and_clear(3'b001, 16'sd3001, 16'sd0, 16'sd0);

        // Start dropped during alignment hold: immediate idle, old zero angle kept
        I_angle_mec = 12'($urandom);
        model_startup(1'b1, 1'b0, 12'd0);
        I_start = 1'b1;
        drain(3000);
        repeat (20) @(posedge I_clk_40m);
        #1;
        exp_q.push_back(base(0, 1'b0, 0));
        I_start = 1'b0;
        drain(20);

        // Init lost in RUN falls back to WAIT_INIT, then re-aligns; trip on -32768
        full_run(12'($urandom));
        exp_q.push_back(base(1, 1'b0, 0));
        I_init_done = 1'b0;
        drain(20);
        model_startup(1'b0, 1'b1, I_angle_mec);
        I_init_done = 1'b1;
        drain(3000);
        fault_and_clear(3'b010, 16'sd0, -16'sd32768, 16'sd0);

        // Randomized trips with random phase masks
        for (int r = 0; r < 3; r++) begin
            full_run(12'($urandom));
            mask = 3'($urandom_range(1, 7));
            for (int p = 0; p < 3; p++) ph[p] = mask[p] ? rand_over() : rand_under();
            fault_and_clear(mask, ph[0], ph[1], ph[2]);
        end

        // Asynchronous reset mid-RUN
        full_run(12'($urandom));
        m_az = '0;
        exp_q.push_back(base(0, 1'b0, 0));
        @(posedge I_clk_40m);
        #2;
        I_rst = 1'b1;
        #1;
        s = cur_snap();
        n_checks++;
        if (s !== base(0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL async_reset: got {%s} required {%s}", fmt(s), fmt(base(0, 1'b0, 0)));
        end
        I_start = 1'b0;
        repeat (2) @(posedge I_clk_40m);
        #1;
        I_rst = 1'b0;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
